// File: rtl/uc_novajogada_fila_if.sv
// Request handshake between the call-entry unit and the elevator dispatcher.
// The master presents the oldest queued floor pair; the slave accepts it with req_ready.
interface uc_novajogada_fila_if #(
  parameter int FLOOR_W = 3
) ();
  logic               req_valid;
  logic               req_ready;
  logic [FLOOR_W-1:0] req_origem;
  logic [FLOOR_W-1:0] req_destino;

  modport master (
    output req_valid,
    output req_origem,
    output req_destino,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_origem,
    input  req_destino,
    output req_ready
  );
endinterface

// File: rtl/uc_novajogada_fila.sv
// Floor-call entry unit: validates origin/destination pairs into a circular request queue.
// Optional destination-wait timeout enabled by defining UC_NOVAJOGADA_TIMEOUT_EN.
module uc_novajogada_fila #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1000,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               nova_entrada,
  input  logic [FLOOR_W-1:0] andar_in,
  uc_novajogada_fila_if.master req,
  output logic [CNT_W-1:0]   ocupacao,
  output logic               cheio,
  output logic               erro,
  output logic               espera_destino
);

  if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH)) begin : g_chk_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if ((1 << FLOOR_W) < NUM_FLOORS) begin : g_chk_floor
    $error("FLOOR_W too narrow for NUM_FLOORS");
  end
  if (TIMEOUT_CYC < 2) begin : g_chk_tmo
    $error("TIMEOUT_CYC must be >= 2");
  end

  typedef enum logic [2:0] {
    INICIAL,
    INICIALIZA,
    ESPERA_ORIGEM,
    GUARDA_ORIGEM,
    ESPERA_DESTINO,
    GUARDA_DESTINO
  } state_t;

  localparam logic [FLOOR_W:0] NF     = NUM_FLOORS[FLOOR_W:0];
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  state_t               state_q, state_d;
  logic                 prev_q, prev_d;
  logic [FLOOR_W-1:0]   origem_q, origem_d;
  logic [PTR_W-1:0]     rd_q, rd_d;
  logic [PTR_W-1:0]     wr_q, wr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [FLOOR_W-1:0]   ho_q, ho_d;
  logic [FLOOR_W-1:0]   hd_q, hd_d;
  logic [2*FLOOR_W-1:0] mem_q [DEPTH];
  logic [2*FLOOR_W-1:0] mem_d [DEPTH];

`ifdef UC_NOVAJOGADA_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  logic                 ev;
  logic                 in_range;
  logic                 push;
  logic                 pop;
  logic [2*FLOOR_W-1:0] head;

  assign ev       = nova_entrada & ~prev_q;
  assign in_range = ({1'b0, andar_in} < NF);
  assign pop      = (cnt_q != '0) & req.req_ready;

  always_comb begin
    state_d  = state_q;
    prev_d   = nova_entrada;
    origem_d = origem_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    mem_d    = mem_q;
    push     = 1'b0;
    head     = '0;
`ifdef UC_NOVAJOGADA_TIMEOUT_EN
    tmr_d    = tmr_q;
`endif

    unique case (state_q)
      INICIAL: begin
        if (iniciar) state_d = INICIALIZA;
      end
      INICIALIZA: begin
        state_d = ESPERA_ORIGEM;
      end
      ESPERA_ORIGEM: begin
        if (ev && in_range) state_d = GUARDA_ORIGEM;
        else if (ev)        err_d   = 1'b1;
      end
      GUARDA_ORIGEM: begin
        origem_d = andar_in;
        state_d  = ESPERA_DESTINO;
`ifdef UC_NOVAJOGADA_TIMEOUT_EN
        tmr_d    = '0;
`endif
      end
      ESPERA_DESTINO: begin
        if (ev) begin
          state_d = GUARDA_DESTINO;
`ifdef UC_NOVAJOGADA_TIMEOUT_EN
        end else if (tmr_q == TMR_LAST) begin
          err_d    = 1'b1;
          origem_d = '0;
          state_d  = ESPERA_ORIGEM;
        end else begin
          tmr_d = tmr_q + 1'b1;
`endif
        end
      end
      GUARDA_DESTINO: begin
        push    = in_range && (andar_in != origem_q) && (cnt_q != FULL_C);
        err_d   = ~push;
        state_d = ESPERA_ORIGEM;
      end
      default: state_d = INICIAL;
    endcase

    if (push) begin
      mem_d[wr_q] = {origem_q, andar_in};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (state_q == INICIALIZA) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end

    // A push into an empty slot at the new head bypasses the memory read.
    if (push && (wr_q == rd_d)) head = {origem_q, andar_in};
    else                        head = mem_q[rd_d];
    if (cnt_d == '0) head = '0;
    ho_d = head[2*FLOOR_W-1:FLOOR_W];
    hd_d = head[FLOOR_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= INICIAL;
      prev_q   <= 1'b0;
      origem_q <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ho_q     <= '0;
      hd_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef UC_NOVAJOGADA_TIMEOUT_EN
      tmr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      origem_q <= origem_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ho_q     <= ho_d;
      hd_q     <= hd_d;
      mem_q    <= mem_d;
`ifdef UC_NOVAJOGADA_TIMEOUT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end

  assign req.req_valid   = (cnt_q != '0);
  assign req.req_origem  = ho_q;
  assign req.req_destino = hd_q;
  assign ocupacao        = cnt_q;
  assign cheio           = (cnt_q == FULL_C);
  assign erro            = err_q;
  assign espera_destino  = (state_q == ESPERA_DESTINO);

endmodule

// File: doc/uc_novajogada_fila.md
Name: uc_novajogada_fila

Overview:
- Parametrised successor to the single-request entry control unit of the elevator manager.
- Captures floor-call pairs (origin, then destination) from the keypad and validates each pair. Accepted pairs go into an internal circular request queue of DEPTH entries.
- Presents the oldest request to the elevator dispatcher over a valid/ready handshake.
- Sits between the keypad/debounce logic and the elevator movement controller.

Parameters:
- NUM_FLOORS, 8: number of valid floors, 0..NUM_FLOORS-1.
- FLOOR_W, 3: floor-number width; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- DEPTH, 4: queue entries; power of two, >= 2.
- TIMEOUT_CYC, 1000: destination-wait timeout in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  level; starts operation from INICIAL.
- nova_entrada  in  1  debounced key level; rising edge detected internally.
- andar_in  in  FLOOR_W  floor number sampled on the detected edge.
- req_ready  in  1  dispatcher accepts the head request.
- req_valid  out  1  queue non-empty.
- req_origem  out  FLOOR_W  head-entry origin.
- req_destino  out  FLOOR_W  head-entry destination.
- ocupacao  out  clog2(DEPTH)+1  entries currently stored.
- cheio  out  1  ocupacao == DEPTH.
- erro  out  1  one-cycle pulse when a pair or key is rejected.
- espera_destino  out  1  high while holding an origin and awaiting a destination.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to INICIAL; queue pointers and ocupacao cleared; origin register cleared; edge-detector register cleared.
  - All outputs 0.
  - A pair in progress is discarded.
- Edge detect: registered previous nova_entrada. ev = nova_entrada & ~prev, one cycle per press.
- FSM states and transitions:
  - INICIAL: goes to INICIALIZA when iniciar=1.
  - INICIALIZA: one cycle; clears queue; goes to ESPERA_ORIGEM.
  - ESPERA_ORIGEM: on ev with andar_in < NUM_FLOORS, go to GUARDA_ORIGEM. On ev with andar_in out of range, pulse erro and stay.
  - GUARDA_ORIGEM: one cycle; latches andar_in into the origin register; goes to ESPERA_DESTINO.
  - ESPERA_DESTINO: espera_destino=1. On ev go to GUARDA_DESTINO.
  - GUARDA_DESTINO: evaluates andar_in and goes to ESPERA_ORIGEM. Accept or reject:
    - Accept, pushing {origem, andar_in}: andar_in in range, andar_in != origem, and the queue is not full.
    - Reject, with erro pulse and no push: any of those checks fails.
    - Full includes the case of a simultaneous pop in the same cycle, so push is never allowed when ocupacao == DEPTH at cycle start.
- GUARDA_ORIGEM latches andar_in on the cycle after ev, so andar_in must stay stable for 2 cycles after the edge. The debounce block guarantees this.
- Queue:
  - Pop occurs when req_valid & req_ready. The head advances on the next edge.
  - req_origem/req_destino are registered from the head slot. Stable while req_valid=1 and req_ready=0.
  - Push latency: the entry is visible on req_valid the cycle after GUARDA_DESTINO.
  - Simultaneous push and pop: both occur; ocupacao unchanged.
  - Pointers wrap modulo DEPTH.
  - Pop on an empty queue is ignored.
- iniciar=1 outside INICIAL has no effect.
- ev arriving in GUARDA_* states is ignored.

Optional Feature:
- Macro: UC_NOVAJOGADA_TIMEOUT_EN.
- Defined: a counter runs in ESPERA_DESTINO and resets on entry to that state. When it reaches TIMEOUT_CYC-1 with no ev:
  - pulse erro;
  - discard the origin;
  - go to ESPERA_ORIGEM.
  - ev in the same cycle as expiry takes priority; no timeout occurs.
- Not defined: no counter; ESPERA_DESTINO waits indefinitely.

Test Plan:
- Reset mid-pair: reset low in ESPERA_DESTINO, then iniciar -> espera_destino=0, ocupacao=0, req_valid=0; next pair 2->5 queues normally.
- Basic pair: iniciar, press floor 1, press floor 6 -> req_valid=1 with origem=1, destino=6, ocupacao=1; req_ready=1 for one cycle -> req_valid=0.
- Invalid inputs, NUM_FLOORS=8, FLOOR_W=4:
  - origin 9 -> erro pulse, state stays ESPERA_ORIGEM;
  - pair 3->3 -> erro pulse, ocupacao stays 0.
- Full and wrap, DEPTH=4:
  - push 4 pairs -> cheio=1;
  - fifth pair -> erro pulse, queue unchanged;
  - pop 2 and push 2 -> order preserved across wrap.
- Simultaneous push and pop with ocupacao=2 -> ocupacao stays 2; head advances; new entry appears at tail.
- With UC_NOVAJOGADA_TIMEOUT_EN, TIMEOUT_CYC=20:
  - origin 4, no further press for 20 cycles -> erro pulse, espera_destino=0, no push;
  - press on cycle 19 -> pair accepted.
